// File: rtl/spi_write_sequencer.sv
// spi_write_sequencer: SPI mode-0 master serialising 16-bit register-write frames
// from two round-robin-arbitrated requesters.
module spi_write_sequencer #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [6:0] req0_addr_i,
    input  logic [7:0] req0_data_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [6:0] req1_addr_i,
    input  logic [7:0] req1_data_i,
    output logic       sclk_o,
    output logic       copi_o,
    output logic       ncs_o,
    output logic       busy_o,
    output logic       grant_id_o,
    output logic       frame_done_o
);
    localparam int M1 = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
    localparam int M2 = M1 > CS_HOLD ? M1 : CS_HOLD;
    localparam int CNT_MAX = M2 > CS_GAP ? M2 : CS_GAP;
    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] GAP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [14:0]   shreg_q, shreg_d;
    logic          sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
    logic          busy_q, fd_q, fd_d, grant_q, grant_d, rr_q, rr_d;
    logic          idle, pick1, accept, cnt_end;

    // The write bit is always 1, so only addr/data are kept in the shifter.
    always_comb begin
        idle = state_q == IDLE;
        pick1 = req1_valid_i && (!req0_valid_i || !rr_q);
        accept = idle && (req0_valid_i || req1_valid_i);
        req0_ready_o = idle && req0_valid_i && !pick1;
        req1_ready_o = idle && pick1;
        cnt_end = cnt_q == (state_q == SETUP ? SETUP_END :
                            state_q == SHIFT ? DIV_END :
                            state_q == HOLD  ? HOLD_END : GAP_END);
        state_d = state_q;
        cnt_d = (idle || cnt_end) ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        shreg_d = shreg_q;
        sclk_d = sclk_q;
        copi_d = copi_q;
        ncs_d = ncs_q;
        fd_d = 1'b0;
        grant_d = grant_q;
        rr_d = rr_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = SETUP;
                shreg_d = pick1 ? {req1_addr_i, req1_data_i} : {req0_addr_i, req0_data_i};
                copi_d = 1'b1;
                ncs_d = 1'b0;
                grant_d = pick1;
                rr_d = pick1;
            end
            SETUP: if (cnt_end) begin
                state_d = SHIFT;
                sclk_d = 1'b1;
                bit_d = '0;
            end
            // copi advances only on the falling transition, keeping it stable while sclk is high
            SHIFT: if (cnt_end) begin
                if (sclk_q) begin
                    sclk_d = 1'b0;
                    copi_d = shreg_q[14];
                    shreg_d = {shreg_q[13:0], 1'b0};
                end else if (bit_q == 4'd15) begin
                    state_d = HOLD;
                end else begin
                    sclk_d = 1'b1;
                    bit_d = bit_q + 4'd1;
                end
            end
            HOLD: if (cnt_end) begin
                state_d = GAP;
                ncs_d = 1'b1;
                fd_d = 1'b1;
                copi_d = 1'b0;
            end
            GAP: if (cnt_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shreg_q <= '0;
            sclk_q <= 1'b0;
            copi_q <= 1'b0;
            ncs_q <= 1'b1;
            busy_q <= 1'b0;
            fd_q <= 1'b0;
            grant_q <= 1'b0;
            rr_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shreg_q <= shreg_d;
            sclk_q <= sclk_d;
            copi_q <= copi_d;
            ncs_q <= ncs_d;
            busy_q <= state_d != IDLE;
            fd_q <= fd_d;
            grant_q <= grant_d;
            rr_q <= rr_d;
        end
    end

    assign sclk_o = sclk_q;
    assign copi_o = copi_q;
    assign ncs_o = ncs_q;
    assign busy_o = busy_q;
    assign grant_id_o = grant_q;
    assign frame_done_o = fd_q;
endmodule

// File: tb/tb_spi_write_sequencer.sv
// tb_spi_write_sequencer: randomized bench comparing the SPI write sequencer against a
// cycle-arithmetic reference model and an SPI frame decoder acting as the peripheral.
module tb_spi_write_sequencer;
    localparam int CLK_DIV = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD = 4;
    localparam int CS_GAP = 8;
    localparam int LOW_LEN = CS_SETUP + 32 * CLK_DIV + CS_HOLD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0;
    logic [6:0] a0 = '0, a1 = '0;
    logic [7:0] d0 = '0, d1 = '0;
    logic r0, r1, sclk, copi, ncs, busy, gid, fdone;
    int n_chk = 0, n_err = 0, cyc = 0;

    spi_write_sequencer #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_addr_i(a0), .req0_data_i(d0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_addr_i(a1), .req1_data_i(d1),
        .sclk_o(sclk), .copi_o(copi), .ncs_o(ncs), .busy_o(busy),
        .grant_id_o(gid), .frame_done_o(fdone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: everything follows from the last accept cycle by plain arithmetic.
    int free_at = 0, acc_last = 0, md, mo, mk, pick;
    bit have_acc = 0, rr = 1, mgrant = 0, e_ncs, e_sclk, e_copi;
    logic [15:0] cur_frame = '0, rx = '0;
    logic [15:0] exp_q[$];
    bit prev_sclk = 0, prev_ncs = 1, prev_copi = 0;
    int edges = 0, total_edges = 0, n_frames = 0, rise_cyc = 0, last_high = 0;
    logic [7:0] regs[128];

    always @(negedge clk) begin
        if (rst) begin
            free_at = 0;
            have_acc = 0;
            rr = 1;
            mgrant = 0;
            exp_q.delete();
            prev_sclk = 0;
            prev_ncs = 1;
            prev_copi = 0;
            edges = 0;
        end else begin
            md = have_acc ? cyc - acc_last : 100000;
            mo = md - 1 - CS_SETUP;
            mk = (mo + CLK_DIV) / (2 * CLK_DIV);
            e_ncs = !(md >= 1 && md <= LOW_LEN);
            e_sclk = mo >= 0 && mo < 32 * CLK_DIV && (mo / CLK_DIV) % 2 == 0;
            e_copi = (md >= 1 && md <= CS_SETUP) ? 1'b1 : (mo >= 0 && mk < 16) ? cur_frame[15 - mk] : 1'b0;
            chk("ncs", ncs, e_ncs);
            chk("sclk", sclk, e_sclk);
            chk("copi", copi, e_copi);
            chk("frame_done", fdone, md == LOW_LEN + 1);
            chk("busy", busy, cyc < free_at);
            chk("grant_id", gid, mgrant);
            pick = -1;
            if (cyc >= free_at && (v0 || v1)) pick = (v0 && v1) ? (rr ? 0 : 1) : (v1 ? 1 : 0);
            chk("ready0", r0, pick == 0);
            chk("ready1", r1, pick == 1);
            if (pick >= 0) begin
                cur_frame = (pick == 1) ? {1'b1, a1, d1} : {1'b1, a0, d0};
                exp_q.push_back(cur_frame);
                acc_last = cyc;
                have_acc = 1;
                free_at = cyc + LOW_LEN + 1 + CS_GAP;
                rr = pick == 1;
                mgrant = pick == 1;
            end
            // Peripheral side: shift in copi on sclk rise, commit the write when ncs rises.
            if (sclk && !prev_sclk) begin
                rx = {rx[14:0], copi};
                edges++;
                total_edges++;
            end
            if (sclk && prev_sclk) chk("copi_stable", copi, prev_copi);
            if (!ncs && prev_ncs) begin
                edges = 0;
                last_high = cyc - rise_cyc;
            end
            if (ncs && !prev_ncs) begin
                chk("edge_count", edges, 16);
                chk("frame_queue", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk("frame", rx, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (rx[15]) regs[rx[14:8]] = rx[7:0];
                n_frames++;
                rise_cyc = cyc;
            end
            prev_sclk = sclk;
            prev_ncs = ncs;
            prev_copi = copi;
        end
    end

    task automatic send(input bit id, input logic [6:0] a, input logic [7:0] dd);
        bit ok = 0;
        @(posedge clk);
        #1;
        if (id) begin v1 = 1; a1 = a; d1 = dd; end
        else begin v0 = 1; a0 = a; d0 = dd; end
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = id ? r1 : r0;
        end
        @(posedge clk);
        #1;
        if (id) v1 = 0; else v0 = 0;
        chk("accept", ok, 1);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 600 && n_frames < n; i++) @(posedge clk);
        chk("frame_wait", n_frames >= n, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int base, te;
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ncs", ncs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_copi", copi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", fdone, 0);
        chk("rst_grant", gid, 0);
        // single write: 0x02 <= 0xA5
        send(0, 7'h02, 8'hA5);
        wait_frames(1);
        chk("reg02", regs[2], 8'hA5);
        // simultaneous requesters after reset alternate starting with req0
        do_reset();
        base = n_frames;
        @(posedge clk);
        #1;
        v0 = 1; v1 = 1; a0 = 7'h11; d0 = 8'h3C; a1 = 7'h22; d1 = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            wait_frames(base + k + 1);
            chk("alternate", gid, k % 2);
        end
        #1;
        v0 = 0; v1 = 0;
        repeat (160) @(posedge clk);
        // req1 held alone: back-to-back frames separated by CS_GAP+1 high cycles
        base = n_frames;
        @(posedge clk);
        #1;
        v1 = 1; a1 = 7'h05; d1 = 8'h5A;
        wait_frames(base + 2);
        chk("ncs_gap", last_high, CS_GAP + 1);
        #1 v1 = 0;
        repeat (160) @(posedge clk);
        // peripheral register writes
        send(0, 7'h00, 8'hFF);
        send(1, 7'h04, 8'h80);
        wait_frames(n_frames + 1);
        chk("en_reg_out_7_0", regs[0], 8'hFF);
        chk("pwm_duty_cycle", regs[4], 8'h80);
        // random traffic with addr/data churning while not ready
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            v0 = $urandom_range(0, 3) == 0;
            v1 = $urandom_range(0, 2) == 0;
            a0 = 7'($urandom_range(0, 127));
            a1 = 7'($urandom_range(0, 127));
            d0 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
        end
        v0 = 0; v1 = 0;
        repeat (200) @(posedge clk);
        // asynchronous reset during bit 7 drops the frame immediately
        send(0, 7'h33, 8'h99);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = edges == 8;
        end
        chk("reach_bit7", seen, 1);
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_ncs", ncs, 1);
        chk("arst_sclk", sclk, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        te = total_edges;
        repeat (50) @(posedge clk);
        chk("no_edges_after_rst", total_edges, te);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
